// File: rtl/tone_player_if.sv
// Handshake bundle between the game logic (master) and the tone player (slave).
interface tone_player_if;
  logic       check;
  logic [3:0] sound;
  logic       buzzer;
  logic       busy;
  logic       stop;
  logic [1:0] step;

  modport master (output check, output sound,
                  input  buzzer, input busy, input stop, input step);
  modport slave  (input  check, input  sound,
                  output buzzer, output busy, output stop, output step);
endinterface

// File: rtl/tone_player.sv
// Piezo tone sequencer: plays scale notes and short jingles on request.
// Define TONE_PLAYER_FAST_EN for shortened simulation timing (half-periods /100).
module tone_player #(
`ifdef TONE_PLAYER_FAST_EN
  parameter int unsigned TONE_LEN = 125_000,
  parameter int unsigned REST_LEN = 25_000,
  parameter int unsigned HP_DIV   = 100
`else
  parameter int unsigned TONE_LEN = 12_500_000,
  parameter int unsigned REST_LEN = 2_500_000,
  parameter int unsigned HP_DIV   = 1
`endif
) (
  input  logic         clk,
  input  logic         reset,
  tone_player_if.slave bus
);

  typedef enum logic [1:0] {IDLE, TONE, REST, DONE} state_t;

  localparam logic [23:0] TONE_LAST = 24'(TONE_LEN - 1);
  localparam logic [23:0] REST_LAST = 24'(REST_LEN - 1);

  state_t      state;
  logic [3:0]  code;
  logic [1:0]  step;
  logic [16:0] hp_cnt;
  logic [23:0] dur_cnt;
  logic        buzzer, busy, stop;
  logic [16:0] half;
  logic [1:0]  last;

  // Note index: 0=do 1=re 2=mi 3=fa 4=so 5=la 6=ti 7=high-do
  function automatic logic [2:0] note_of(input logic [3:0] c, input logic [1:0] s);
    case (c)
      4'd9:    note_of = (s == 2'd0) ? 3'd3 : 3'd0;
      4'd10:   case (s)
                 2'd0:    note_of = 3'd0;
                 2'd1:    note_of = 3'd2;
                 default: note_of = 3'd4;
               endcase
      4'd11:   case (s)
                 2'd0:    note_of = 3'd0;
                 2'd1:    note_of = 3'd2;
                 2'd2:    note_of = 3'd4;
                 default: note_of = 3'd7;
               endcase
      4'd12:   case (s)
                 2'd0:    note_of = 3'd4;
                 2'd1:    note_of = 3'd3;
                 2'd2:    note_of = 3'd2;
                 default: note_of = 3'd0;
               endcase
      default: note_of = 3'(c - 4'd1);
    endcase
  endfunction

  function automatic logic [1:0] last_of(input logic [3:0] c);
    case (c)
      4'd9:          last_of = 2'd1;
      4'd10:         last_of = 2'd2;
      4'd11, 4'd12:  last_of = 2'd3;
      default:       last_of = 2'd0;
    endcase
  endfunction

  function automatic logic [16:0] half_of(input logic [2:0] n);
    case (n)
      3'd0:    half_of = 17'(95420 / HP_DIV);
      3'd1:    half_of = 17'(85034 / HP_DIV);
      3'd2:    half_of = 17'(75758 / HP_DIV);
      3'd3:    half_of = 17'(71633 / HP_DIV);
      3'd4:    half_of = 17'(63776 / HP_DIV);
      3'd5:    half_of = 17'(56818 / HP_DIV);
      3'd6:    half_of = 17'(50607 / HP_DIV);
      default: half_of = 17'(47801 / HP_DIV);
    endcase
  endfunction

  always_comb begin
    half = half_of(note_of(code, step));
    last = last_of(code);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      code    <= 4'd0;
      step    <= 2'd0;
      hp_cnt  <= 17'd0;
      dur_cnt <= 24'd0;
      buzzer  <= 1'b0;
      busy    <= 1'b0;
      stop    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          buzzer  <= 1'b0;
          step    <= 2'd0;
          stop    <= 1'b0;
          hp_cnt  <= 17'd0;
          dur_cnt <= 24'd0;
          if (bus.check) begin
            code <= bus.sound;
            if (bus.sound != 4'd0 && bus.sound <= 4'd12) begin
              state <= TONE;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              stop  <= 1'b1;
            end
          end
        end
        TONE: begin
          // End of the note wins over a coincident half-period toggle.
          if (dur_cnt == TONE_LAST) begin
            state   <= REST;
            buzzer  <= 1'b0;
            dur_cnt <= 24'd0;
            hp_cnt  <= 17'd0;
          end else begin
            dur_cnt <= dur_cnt + 24'd1;
            if (hp_cnt == half - 17'd1) begin
              hp_cnt <= 17'd0;
              buzzer <= ~buzzer;
            end else begin
              hp_cnt <= hp_cnt + 17'd1;
            end
          end
        end
        REST: begin
          if (dur_cnt == REST_LAST) begin
            dur_cnt <= 24'd0;
            hp_cnt  <= 17'd0;
            if (step == last) begin
              state <= DONE;
              busy  <= 1'b0;
              stop  <= 1'b1;
            end else begin
              step  <= step + 2'd1;
              state <= TONE;
            end
          end else begin
            dur_cnt <= dur_cnt + 24'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          stop  <= 1'b0;
          step  <= 2'd0;
        end
      endcase
    end
  end

  assign bus.buzzer = buzzer;
  assign bus.busy   = busy;
  assign bus.stop   = stop;
  assign bus.step   = step;

endmodule

// File: tb/tb_tone_player.sv
// Scoreboard bench for tone_player using shortened note/rest lengths.
module tb_tone_player;
  localparam int TONE = 3000;
  localparam int REST = 500;
  localparam int DIV  = 100;

  localparam logic [1:0] K_NOTE = 2'd1;
  localparam logic [1:0] K_STOP = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  step;
    logic [15:0] a, b, c, d;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  tone_player_if bus();

  tone_player #(.TONE_LEN(TONE), .REST_LEN(REST), .HP_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  function automatic int half_ref(input int note);
    case (note)
      0: return 95420 / DIV;
      1: return 85034 / DIV;
      2: return 75758 / DIV;
      3: return 71633 / DIV;
      4: return 63776 / DIV;
      5: return 56818 / DIV;
      6: return 50607 / DIV;
      default: return 47801 / DIV;
    endcase
  endfunction

  function automatic int rises_of(input int note);
    return ((TONE - 1) / half_ref(note) + 1) / 2;
  endfunction

  function automatic ev_t note_ev(input int s, input int note);
    ev_t e;
    e = '0;
    e.kind = K_NOTE;
    e.step = 2'(s);
    e.a = 16'(half_ref(note));
    e.b = 16'(half_ref(note));
    return e;
  endfunction

  function automatic ev_t stop_ev(input int busy_cyc, input int rises, input int after);
    ev_t e;
    e = '0;
    e.kind = K_STOP;
    e.a = 16'd1;
    e.b = 16'(busy_cyc);
    e.c = 16'(rises);
    e.d = 16'(after);
    return e;
  endfunction

  // Output monitor: turns buzzer/busy/stop activity into events.
  int n = 0, note_start = 0, rise_n = 0, stop_n = 0, busy_cyc = 0, rises = 0, after = 0;
  bit rise_seen = 0, fall_seen = 0, pb = 0, pz = 0, ps = 0;
  logic [1:0] pstep = 2'd0, note_step = 2'd0;

  always @(negedge clk) begin
    ev_t e;
    n++;
    if (!reset) begin
      rise_seen = 0; fall_seen = 0; busy_cyc = 0; rises = 0;
      pb = 0; pz = 0; ps = 0; pstep = 2'd0;
    end else begin
      if (bus.busy) busy_cyc++;
      if (bus.busy && (!pb || bus.step != pstep)) begin
        note_start = n; note_step = bus.step; rise_seen = 0; fall_seen = 0;
      end
      if (bus.buzzer && !pz) begin
        rises++;
        if (!rise_seen) begin rise_seen = 1; rise_n = n; end
      end
      if (!bus.buzzer && pz && rise_seen && !fall_seen) begin
        fall_seen = 1;
        e = '0;
        e.kind = K_NOTE;
        e.step = note_step;
        e.a = 16'(rise_n - note_start);
        e.b = 16'(n - rise_n);
        obs_q.push_back(e);
      end
      if (bus.stop && !ps) begin stop_n = n; after = int'(pb); end
      if (!bus.stop && ps) begin
        e = '0;
        e.kind = K_STOP;
        e.a = 16'(n - stop_n);
        e.b = 16'(busy_cyc);
        e.c = 16'(rises);
        e.d = 16'(after);
        obs_q.push_back(e);
        busy_cyc = 0; rises = 0;
      end
      pb = bus.busy; pz = bus.buzzer; ps = bus.stop; pstep = bus.step;
    end
  end

  task automatic test_reset;
    bus.check = 1'b0;
    bus.sound = 4'd0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.buzzer, bus.busy, bus.stop} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got %b want 000", {bus.buzzer, bus.busy, bus.stop});
    end
    total++;
    if (bus.step !== 2'd0) begin
      bad++; $display("FAIL reset_step got %0d want 0", bus.step);
    end
    reset = 1'b1;
  endtask

  task automatic test_single;
    exp_q.push_back(note_ev(0, 5));
    exp_q.push_back(stop_ev(TONE + REST, rises_of(5), 1));
    bus.sound = 4'd6;
    bus.check = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus.busy, bus.stop} !== 2'b10) begin
      bad++; $display("FAIL single_accept got busy/stop=%b want 10", {bus.busy, bus.stop});
    end
    bus.check = 1'b0;
    for (int i = 0; i < 20000 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    while (exp_q.size() > 0) begin
      ev_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL single_ev got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL single_ev got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_sequence;
    int notes[4] = '{0, 2, 4, 7};
    int r = 0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(note_ev(i, notes[i]));
      r += rises_of(notes[i]);
    end
    exp_q.push_back(stop_ev(4 * (TONE + REST), r, 1));
    bus.sound = 4'd11;
    bus.check = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL seq_accept got busy=%b want 1", bus.busy); end
    bus.check = 1'b0;
    for (int i = 0; i < 20000 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    while (exp_q.size() > 0) begin
      ev_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL seq_ev got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL seq_ev got %h want %h", o, e); end
      end
    end
    repeat (20) @(negedge clk);
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL seq_extra got %0d events want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_invalid;
    logic [3:0] codes[3] = '{4'd0, 4'd13, 4'd15};
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(stop_ev(0, 0, 0));
      bus.sound = codes[k];
      bus.check = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({bus.busy, bus.stop, bus.buzzer} !== 3'b010) begin
        bad++; $display("FAIL invalid_%0d got busy/stop/buz=%b want 010", codes[k], {bus.busy, bus.stop, bus.buzzer});
      end
      bus.check = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({bus.busy, bus.stop} !== 2'b00) begin
        bad++; $display("FAIL invalid_pulse_%0d got busy/stop=%b want 00", codes[k], {bus.busy, bus.stop});
      end
      @(negedge clk);
    end
    for (int i = 0; i < 100 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    while (exp_q.size() > 0) begin
      ev_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL invalid_ev got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL invalid_ev got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_ignore;
    int notes[4] = '{4, 3, 2, 0};
    int r = 0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(note_ev(i, notes[i]));
      r += rises_of(notes[i]);
    end
    exp_q.push_back(stop_ev(4 * (TONE + REST), r, 1));
    bus.sound = 4'd12;
    bus.check = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL ignore_accept got busy=%b want 1", bus.busy); end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.check = ~bus.check;
      bus.sound = 4'd3;
    end
    bus.check = 1'b1;
    repeat (5000) @(negedge clk);
    bus.check = 1'b0;
    for (int i = 0; i < 20000 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    while (exp_q.size() > 0) begin
      ev_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL ignore_ev got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL ignore_ev got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_q.push_back(note_ev(0, 0));
    bus.sound = 4'd10;
    bus.check = 1'b1;
    @(posedge clk); #1;
    bus.check = 1'b0;
    for (int i = 0; i < 10000 && bus.step !== 2'd1; i++) @(negedge clk);
    repeat (900) @(negedge clk);
    total++;
    if ({bus.buzzer, bus.busy, bus.step} !== 4'b1101) begin
      bad++; $display("FAIL midnote_state got buz/busy/step=%b want 1101", {bus.buzzer, bus.busy, bus.step});
    end
    #3 reset = 1'b0;
    #1;
    total++;
    if ({bus.buzzer, bus.busy, bus.stop, bus.step} !== 5'b00000) begin
      bad++; $display("FAIL async_reset got buz/busy/stop/step=%b want 00000", {bus.buzzer, bus.busy, bus.stop, bus.step});
    end
    while (exp_q.size() > 0) begin
      ev_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL premid_ev got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL premid_ev got %h want %h", o, e); end
      end
    end
    obs_q.delete();
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(note_ev(0, 0));
    exp_q.push_back(stop_ev(TONE + REST, rises_of(0), 1));
    reset = 1'b1;
    bus.sound = 4'd1;
    bus.check = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL post_reset_accept got busy=%b want 1", bus.busy); end
    bus.check = 1'b0;
    for (int i = 0; i < 20000 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    while (exp_q.size() > 0) begin
      ev_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL postrst_ev got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL postrst_ev got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(note_ev(0, 1));
      exp_q.push_back(stop_ev(TONE + REST, rises_of(1), 1));
    end
    bus.sound = 4'd2;
    bus.check = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got busy=%b want 1", bus.busy); end
    for (int i = 0; i < 10000 && bus.stop !== 1'b1; i++) @(negedge clk);
    total++;
    if (bus.stop !== 1'b1) begin bad++; $display("FAIL b2b_first_stop got %b want 1", bus.stop); end
    @(posedge clk); #1;
    total++;
    if ({bus.busy, bus.stop} !== 2'b00) begin
      bad++; $display("FAIL b2b_idle got busy/stop=%b want 00", {bus.busy, bus.stop});
    end
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_restart got busy=%b want 1", bus.busy); end
    bus.check = 1'b0;
    for (int i = 0; i < 20000 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    while (exp_q.size() > 0) begin
      ev_t e, o;
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL b2b_ev got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL b2b_ev got %h want %h", o, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_invalid();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(95000 * 20);
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/tone_player.md
TONE_PLAYER -- requirements
Module: tone_player

Interface
REQ-001 clk  input  1  system clock, 50 MHz; all state on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 check  input  1  request level from game logic; held high until stop is seen.
REQ-004 sound  input  4  sound code qualified by check: 1..8 scale note, 9 wrong, 10 level-up, 11 win, 12 game-over, others invalid.
REQ-005 buzzer  output  1  square-wave drive to the piezo.
REQ-006 busy  output  1  high while a code is being played.
REQ-007 stop  output  1  one-cycle completion pulse, wired to the game block's stop input.
REQ-008 step  output  2  index of the current note within the sequence, for debug.

Function
REQ-009 The FSM SHALL have the states IDLE, TONE, REST and DONE; busy = (state is TONE or REST); stop = (state is DONE).
REQ-010 In IDLE with check=1, the block SHALL latch sound and go to TONE with step=0 if the code is 1..12, else to DONE.
REQ-011 Latency SHALL be one cycle: check sampled high at edge k gives busy or stop high after edge k.
REQ-012 While not IDLE, check and sound SHALL be ignored; the latched code SHALL NOT change.
REQ-013 Note half-periods (cycles) SHALL be: do 95420, re 85034, mi 75758, fa 71633, so 63776, la 56818, ti 50607, high-do 47801; codes 1..8 map in that order.
REQ-014 The sequences SHALL be: codes 1..8 = one note; 9 = fa, do; 10 = do, mi, so; 11 = do, mi, so, high-do; 12 = so, fa, mi, do.
REQ-015 In TONE, the 17-bit half-period counter SHALL start at 0 on state entry; when it reaches half-period-1, it SHALL clear and buzzer SHALL toggle. The first toggle is 0->1.
REQ-016 TONE SHALL last exactly 12,500,000 cycles (24-bit duration counter), then go to REST with buzzer forced to 0 on the same edge.
REQ-017 REST SHALL last 2,500,000 cycles. If step is the last index, the FSM SHALL go to DONE; otherwise it SHALL increment step and go to TONE.
REQ-018 DONE SHALL last exactly one cycle, then go to IDLE. If check is still high in the next IDLE cycle, that SHALL be treated as a new request.
REQ-019 buzzer SHALL be 0 in IDLE, REST and DONE; step SHALL be 0 in IDLE.
REQ-020 Counters SHALL never wrap: the duration counter clears on every state change, and the half-period counter clears on TONE entry.

Reset
REQ-021 When reset is asserted, at any time including mid-note, the block SHALL immediately apply: state=IDLE, buzzer=0, busy=0, stop=0, step=0, all counters 0, latched code 0.
REQ-022 After reset deasserts, the first request SHALL be accepted on the first edge with check=1.

Configuration
REQ-023 When macro TONE_PLAYER_FAST_EN is defined, half-periods SHALL be the table values divided by 100 (truncated), TONE SHALL be 125,000 cycles and REST 25,000 cycles, for simulation.
REQ-024 When TONE_PLAYER_FAST_EN is undefined, the full values of REQ-013, REQ-016 and REQ-017 SHALL apply; the FSM and handshake SHALL be identical in both builds.

Verification (TONE_PLAYER_FAST_EN defined)
REQ-025 sound=6, check=1 at edge k -> busy=1 after k; buzzer rises 568 cycles after TONE entry; 125,000 TONE cycles + 25,000 REST cycles; then stop=1 for exactly 1 cycle; busy=0.
REQ-026 sound=11 -> step goes 0,1,2,3; half-periods 954, 757, 637, 478; stop pulses once, 600,000 cycles after acceptance.
REQ-027 sound=0 or 13, check=1 -> stop=1 on the next cycle, busy never rises, buzzer stays 0.
REQ-028 During sound=12, sound changes to 3 and check toggles -> no effect; four notes play, then one stop pulse.
REQ-029 reset is pulsed low mid-TONE of sound=10 -> buzzer, busy, stop and step are 0 immediately; after release with check=1, sound=1 -> a fresh single do note plays.
REQ-030 check is held high across DONE with sound=2 -> a second re note starts on the cycle after IDLE is re-entered.
